// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board top level and the CPU clock-enable controller.
// The top level drives the switch, button and halt request; the controller drives the strobe
// and its status.
interface cpu_clk_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             mode_run;
  logic             step_btn;
  logic             halt_req;
  logic             clk_cpu_en;
  logic [CNT_W-1:0] cpu_cycles;
  logic [1:0]       state;
  logic             halted;

  modport master (
    output mode_run,
    output step_btn,
    output halt_req,
    input  clk_cpu_en,
    input  cpu_cycles,
    input  state,
    input  halted
  );

  modport slave (
    input  mode_run,
    input  step_btn,
    input  halt_req,
    output clk_cpu_en,
    output cpu_cycles,
    output state,
    output halted
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing the single-cycle CPU clock-enable strobe.
// It also counts the strobes it has issued.
module cpu_clk_ctrl #(
  parameter int unsigned DIV_N      = 50_000_000,
  parameter int unsigned DEBOUNCE_N = 1_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_clk_ctrl_if.slave bus
);

  localparam int unsigned DivW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(DIV_N - 1);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_N - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } state_e;

  logic             mode_q1, mode_s_q;
  logic             btn_q1, btn_s_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             db_btn_q, db_btn_d;
  logic             db_btn_dly_q;
  logic             step_evt;
  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    db_btn_d = db_btn_q;
    if (btn_s_q == db_btn_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbMax) begin
      db_btn_d = btn_s_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  // Rising edge of the accepted level only; a release never steps.
  assign step_evt = db_btn_q & ~db_btn_dly_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (mode_s_q) begin
          state_d = StRun;
          div_d   = '0;
        end else if (step_evt) begin
          state_d = StStep;
          en_d    = 1'b1;
        end
      end
      StStep: begin
        state_d = bus.halt_req ? StHalt : StIdle;
      end
      StRun: begin
        // Halt and mode change both win over a strobe falling due this cycle.
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (!mode_s_q) begin
          state_d = StIdle;
          div_d   = '0;
        end else begin
          en_d  = (div_q == DivMax);
          div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  assign halted_d = (state_d == StHalt);
  assign cnt_d    = cnt_q + CNT_W'(en_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q1      <= 1'b0;
      mode_s_q     <= 1'b0;
      btn_q1       <= 1'b0;
      btn_s_q      <= 1'b0;
      db_cnt_q     <= '0;
      db_btn_q     <= 1'b0;
      db_btn_dly_q <= 1'b0;
      state_q      <= StIdle;
      div_q        <= '0;
      en_q         <= 1'b0;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
    end else begin
      mode_q1      <= bus.mode_run;
      mode_s_q     <= mode_q1;
      btn_q1       <= bus.step_btn;
      btn_s_q      <= btn_q1;
      db_cnt_q     <= db_cnt_d;
      db_btn_q     <= db_btn_d;
      db_btn_dly_q <= db_btn_q;
      state_q      <= state_d;
      div_q        <= div_d;
      en_q         <= en_d;
      cnt_q        <= cnt_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.clk_cpu_en = en_q;
  assign bus.cpu_cycles = cnt_q;
  assign bus.state      = state_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus a random phase, all checked each cycle
// against a behavioural model of the run/step/halt rules.
module tb_cpu_clk_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_clk_ctrl_if #(.CNT_W(8)) bus ();

  cpu_clk_ctrl #(
    .DIV_N      (DIV),
    .DEBOUNCE_N (DEB),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes[$];

  // Model: 0 idle, 1 run, 2 step, 3 halt.
  int       m_state, m_age, m_streak;
  bit       m_acc, m_rose, m_en;
  logic [7:0] m_cnt;
  bit       ms_pipe[2];
  bit       bs_pipe[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_step();
    bit ms, bs, evt, en_next, old_acc;
    int nxt;
    if (!rst_n) begin
      m_state = 0; m_age = 0; m_streak = 0;
      m_acc = 0; m_rose = 0; m_en = 0; m_cnt = 8'h00;
      ms_pipe[0] = 0; ms_pipe[1] = 0; bs_pipe[0] = 0; bs_pipe[1] = 0;
      return;
    end
    ms = ms_pipe[1];
    bs = bs_pipe[1];
    evt = m_rose;
    en_next = 0;
    nxt = m_state;
    m_cnt = m_cnt + 8'(m_en);
    case (m_state)
      0: begin
        if (bus.halt_req) nxt = 3;
        else if (ms) begin nxt = 1; m_age = 0; end
        else if (evt) begin nxt = 2; en_next = 1; end
      end
      1: begin
        if (bus.halt_req) nxt = 3;
        else if (!ms) nxt = 0;
        else begin
          en_next = ((m_age % DIV) == DIV - 1);
          m_age++;
        end
      end
      2: nxt = bus.halt_req ? 3 : 0;
      default: nxt = 3;
    endcase
    m_state = nxt;
    m_en = en_next;
    // Accepted level follows the synced button once it has differed for DEB straight cycles.
    old_acc = m_acc;
    if (bs == m_acc) m_streak = 0;
    else begin
      m_streak++;
      if (m_streak == DEB) begin m_acc = bs; m_streak = 0; end
    end
    m_rose = m_acc & ~old_acc;
    ms_pipe[1] = ms_pipe[0]; ms_pipe[0] = bus.mode_run;
    bs_pipe[1] = bs_pipe[0]; bs_pipe[0] = bus.step_btn;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("en", 32'(bus.clk_cpu_en), 32'(m_en));
    chk("cycles", 32'(bus.cpu_cycles), 32'(m_cnt));
    chk("state", 32'(bus.state), 32'(m_state));
    chk("halted", 32'(bus.halted), 32'(m_state == 3));
    if (bus.clk_cpu_en) strobes.push_back(cyc);
  endtask

  initial begin
    int base, bad, c0;
    bus.mode_run = 0; bus.step_btn = 0; bus.halt_req = 0;

    // 1: free run
    rst_n = 0; tick(); tick(); rst_n = 1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_en", 32'(bus.clk_cpu_en), 0);
    strobes.delete(); base = cyc; bus.mode_run = 1;
    repeat (40) tick();
    chk("t1_count", strobes.size(), 9);
    bad = 0;
    for (int i = 1; i < strobes.size(); i++) if (strobes[i] - strobes[i-1] != DIV) bad++;
    chk("t1_spacing", bad, 0);
    if (strobes.size() > 0) chk("t1_first", strobes[0] - base, 7);
    chk("t1_cycles", 32'(bus.cpu_cycles), strobes.size());

    // 2: bouncing then held step button
    bus.mode_run = 0; repeat (6) tick();
    strobes.delete();
    for (int s = 0; s < 10; s++) begin
      bus.step_btn = (s % 2 == 0);
      repeat (3) tick();
    end
    chk("t2_bounce", strobes.size(), 0);
    c0 = int'(bus.cpu_cycles); base = cyc; bus.step_btn = 1;
    repeat (20) tick();
    chk("t2_one", strobes.size(), 1);
    if (strobes.size() > 0) chk("t2_delay", strobes[0] - base, 11);
    chk("t2_cycles", 32'(bus.cpu_cycles), 32'((c0 + 1) % 256));
    strobes.delete(); bus.step_btn = 0;
    repeat (20) tick();
    chk("t2_release", strobes.size(), 0);

    // 3: halt exactly when a strobe falls due
    strobes.delete(); bus.mode_run = 1;
    repeat (10) tick();
    chk("t3_pre", strobes.size(), 1);
    bus.halt_req = 1; tick();
    chk("t3_en", 32'(bus.clk_cpu_en), 0);
    chk("t3_state", 32'(bus.state), 3);
    chk("t3_halted", 32'(bus.halted), 1);
    bus.halt_req = 0; strobes.delete();
    bus.mode_run = 0; repeat (5) tick();
    bus.mode_run = 1; repeat (5) tick();
    bus.mode_run = 0; bus.step_btn = 1; repeat (15) tick();
    bus.step_btn = 0; repeat (12) tick();
    chk("t3_none", strobes.size(), 0);
    chk("t3_stuck", 32'(bus.state), 3);

    // 4: counter wrap
    rst_n = 0; tick(); rst_n = 1; bus.mode_run = 1;
    for (int i = 0; i < 1200 && bus.cpu_cycles != 8'hFE; i++) tick();
    chk("t4_preset", 32'(bus.cpu_cycles), 32'h00FE);
    strobes.delete();
    for (int i = 0; i < 20 && strobes.size() < 2; i++) tick();
    tick();
    chk("t4_wrap", 32'(bus.cpu_cycles), 0);

    // 5: reset mid-run and mid-debounce
    bus.step_btn = 1; repeat (5) tick();
    rst_n = 0; tick();
    chk("t5_en", 32'(bus.clk_cpu_en), 0);
    chk("t5_cycles", 32'(bus.cpu_cycles), 0);
    chk("t5_state", 32'(bus.state), 0);
    chk("t5_halted", 32'(bus.halted), 0);
    rst_n = 1; bus.mode_run = 0; base = cyc; strobes.delete();
    repeat (20) tick();
    chk("t5_one", strobes.size(), 1);
    if (strobes.size() > 0) chk("t5_delay", strobes[0] - base, 11);
    bus.step_btn = 0; repeat (15) tick();

    // 6: press accepted during run is lost
    bus.mode_run = 1; repeat (8) tick();
    bus.step_btn = 1; repeat (20) tick();
    bus.mode_run = 0; repeat (4) tick();
    chk("t6_idle", 32'(bus.state), 0);
    strobes.delete();
    repeat (20) tick();
    chk("t6_none", strobes.size(), 0);
    bus.step_btn = 0; repeat (15) tick();

    // Random phase
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) bus.mode_run = ~bus.mode_run;
      if ($urandom_range(0, 5) == 0) bus.step_btn = 1'($urandom_range(0, 1));
      bus.halt_req = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
